// File: rtl/abs_pkg.sv
// Shared definitions for the abs_pipe block.
//   ABS_WIDTH_DEFAULT : default sample width in bits
//   occ_state_t       : output FIFO occupancy (EMPTY / ONE / TWO)
package abs_pkg;

  localparam int ABS_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/abs_core.sv
// Combinational absolute value of a two's-complement sample.
// Ports:
//   data   : signed input sample, WIDTH bits
//   result : absolute value as a WIDTH-bit signed result
//   mag    : exact unsigned magnitude (most-negative gives 2^(WIDTH-1))
//   ovf    : data is the most-negative value, -2^(WIDTH-1)
// Build option: define ABS_SAT_EN to saturate result to 2^(WIDTH-1)-1 for
// the most-negative input; otherwise result wraps to -2^(WIDTH-1).
module abs_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] mag,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    // Read as unsigned, the two's-complement negation of MOST_NEG is exactly
    // 2^(WIDTH-1), so mag needs no extra bit.
    mag = data[WIDTH-1] ? ((~data) + ONE_VAL) : data;
    ovf = (data == MOST_NEG);
`ifdef ABS_SAT_EN
    result = ovf ? {1'b0, {(WIDTH-1){1'b1}}} : mag;
`else
    result = mag;
`endif
  end

endmodule

// File: rtl/abs_pipe.sv
// Absolute-value pipeline with a two-entry output FIFO and a peak tracker.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake, in_data is the signed sample
//   out_valid/out_ready  : output handshake, out_data/out_ovf carry the result
//   peak_clr             : synchronous clear of peak_mag
//   peak_mag             : running maximum unsigned magnitude
//   occ_state            : debug view of FIFO occupancy state
// Build option: ABS_SAT_EN (see abs_core) selects saturation of the
// most-negative input.
// Handshake: a transfer happens on a rising edge where valid && ready; a
// producer holds its payload stable while valid && !ready. in_ready is a
// register and has no combinational dependence on out_ready.
module abs_pipe
  import abs_pkg::*;
#(
  parameter int WIDTH = ABS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  input  logic             peak_clr,
  output logic [WIDTH-1:0] peak_mag,
  output occ_state_t       occ_state
);

  occ_state_t       state;
  occ_state_t       state_nxt;
  logic [WIDTH-1:0] head_data;
  logic             head_ovf;
  logic [WIDTH-1:0] skid_data;
  logic             skid_ovf;
  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] core_mag;
  logic             core_ovf;
  logic             in_xfer;
  logic             out_xfer;

  abs_core #(.WIDTH(WIDTH)) u_core (
    .data   (in_data),
    .result (core_result),
    .mag    (core_mag),
    .ovf    (core_ovf)
  );

  assign out_valid = (state != EMPTY);
  assign out_data  = head_data;
  assign out_ovf   = head_ovf;
  assign occ_state = state;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_xfer) state_nxt = ONE;
      ONE: begin
        if (in_xfer && !out_xfer)      state_nxt = TWO;
        else if (!in_xfer && out_xfer) state_nxt = EMPTY;
      end
      TWO:     if (out_xfer) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      head_data <= '0;
      head_ovf  <= 1'b0;
      skid_data <= '0;
      skid_ovf  <= 1'b0;
      peak_mag  <= '0;
    end else begin
      state    <= state_nxt;
      // Registered so the next cycle's acceptance depends only on occupancy.
      in_ready <= (state_nxt != TWO);

      case (state)
        EMPTY: begin
          if (in_xfer) begin
            head_data <= core_result;
            head_ovf  <= core_ovf;
          end
        end
        ONE: begin
          // With a simultaneous pop the new result replaces the head directly;
          // otherwise it parks in the skid register behind the head.
          if (in_xfer && out_xfer) begin
            head_data <= core_result;
            head_ovf  <= core_ovf;
          end else if (in_xfer) begin
            skid_data <= core_result;
            skid_ovf  <= core_ovf;
          end
        end
        TWO: begin
          // in_ready is low in TWO, so only a pop can happen here.
          if (out_xfer) begin
            head_data <= skid_data;
            head_ovf  <= skid_ovf;
          end
        end
        default: ;
      endcase

      if (peak_clr) begin
        peak_mag <= in_xfer ? core_mag : '0;
      end else if (in_xfer && (core_mag > peak_mag)) begin
        peak_mag <= core_mag;
      end
    end
  end

endmodule

// File: tb/tb_abs_pipe.sv
// Directed self-checking bench for abs_pipe at WIDTH=4.
module tb_abs_pipe;
  import abs_pkg::*;

  localparam int W = 4;

`ifdef ABS_SAT_EN
  localparam logic [W-1:0] EXP_MOST_NEG = 4'd7;
`else
  localparam logic [W-1:0] EXP_MOST_NEG = 4'd8;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         peak_clr = 1'b0;
  logic [W-1:0] peak_mag;
  occ_state_t   occ_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp = '0;
  int           n_checks = 0;
  int           n_errors = 0;

  abs_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .peak_clr  (peak_clr),
    .peak_mag  (peak_mag),
    .occ_state (occ_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard bookkeeping just before the edge, then advance to edge + 1.
  task automatic step();
    if (in_valid && in_ready) exp_q.push_back(cur_exp);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_extra: got %0d expected none", out_data);
      end else begin
        chk("sb_order", out_data, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] d, input logic [W-1:0] e);
    in_valid = 1'b1;
    in_data  = d;
    cur_exp  = e;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  logic [W-1:0] tp_in  [10] = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
  logic [W-1:0] tp_exp [10] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

  initial begin
    // reset, asserted asynchronously before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_peak", peak_mag, 0);
    chk("rst_state", occ_state, EMPTY);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rel_in_ready_low", in_ready, 0);
    step();
    chk("rel_in_ready_high", in_ready, 1);

    // 3 then -4, one cycle latency
    offer(4'd3, 4'd3);
    step();
    chk("lat_valid", out_valid, 1);
    chk("lat_data3", out_data, 3);
    chk("lat_ovf3", out_ovf, 0);
    offer(4'hC, 4'd4);
    step();
    chk("lat_data4", out_data, 4);
    chk("lat_ovf4", out_ovf, 0);
    chk("lat_state_one", occ_state, ONE);
    idle();
    step();
    chk("lat_drained", out_valid, 0);
    chk("peak_4", peak_mag, 4);

    // most-negative input
    offer(4'h8, EXP_MOST_NEG);
    step();
    chk("neg_ovf", out_ovf, 1);
    chk("neg_data", out_data, EXP_MOST_NEG);
    chk("neg_peak", peak_mag, 8);
    idle();
    step();

    // peak tracking and clear
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    chk("clr_alone_a", peak_mag, 0);
    offer(4'd1, 4'd1);
    step();
    chk("peak_1", peak_mag, 1);
    offer(4'hA, 4'd6);
    step();
    chk("peak_6", peak_mag, 6);
    chk("data_6", out_data, 6);
    offer(4'd3, 4'd3);
    step();
    chk("peak_6_hold", peak_mag, 6);
    offer(4'd2, 4'd2);
    peak_clr = 1'b1;
    step();
    chk("clr_with_in", peak_mag, 2);
    idle();
    step();
    peak_clr = 1'b0;
    chk("clr_alone_b", peak_mag, 0);
    chk("peak_drained", out_valid, 0);

    // backpressure: fill both entries, third sample held off
    out_ready = 1'b0;
    offer(4'd1, 4'd1);
    step();
    chk("bp_one_ready", in_ready, 1);
    offer(4'd2, 4'd2);
    step();
    chk("bp_two_state", occ_state, TWO);
    chk("bp_two_ready", in_ready, 0);
    offer(4'd3, 4'd3);
    step();
    chk("bp_hold_data", out_data, 1);
    chk("bp_hold_state", occ_state, TWO);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("bp_out2", out_data, 2);
    chk("bp_ready_back", in_ready, 1);
    step();
    chk("bp_out3", out_data, 3);
    idle();
    step();
    chk("bp_drained", out_valid, 0);

    // full throughput in state ONE
    offer(4'd7, 4'd7);
    step();
    for (int i = 0; i < 10; i++) begin
      offer(tp_in[i], tp_exp[i]);
      step();
      chk("tp_state", occ_state, ONE);
      chk("tp_data", out_data, tp_exp[i]);
    end
    idle();
    step();
    chk("tp_drained", out_valid, 0);

    // asynchronous reset while TWO
    out_ready = 1'b0;
    offer(4'd5, 4'd5);
    step();
    offer(4'hA, 4'd6);
    step();
    idle();
    chk("ar_pre_state", occ_state, TWO);
    #3 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_peak", peak_mag, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_out_data", out_data, 0);
    exp_q.delete();
    step();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("ar_rel_ready", in_ready, 1);
    chk("ar_no_stale", out_valid, 0);
    step();
    chk("ar_no_stale2", out_valid, 0);
    offer(4'hE, 4'd2);
    step();
    chk("ar_after_data", out_data, 2);
    idle();
    step();

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
